core_ctrl_fsm: RTL
==================

CORE_CTRL_FSM -- requirements
Module: core_ctrl_fsm

Interface
REQ-001 SHALL have parameter TRAP_ON_ILLEGAL, default 1; when 1, an illegal opcode parks the FSM in TRAP; when 0, it is retired as a NOP.
REQ-002 SHALL have one clock; reset is synchronous and active-low (clk, rst_n).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 instr  in  32  current instruction register contents.
REQ-006 br_taken  in  1  ALU branch-compare result, valid in EXEC.
REQ-007 imem_req / imem_ready  out 1 / in 1  instruction fetch handshake.
REQ-008 dmem_req / dmem_we / dmem_ready  out 1 / out 1 / in 1  data access handshake.
REQ-009 ir_we, pc_we, rf_we  out  1 each  register write strobes.
REQ-010 pc_sel  out  2  PC source: 0=pc+4, 1=pc+imm, 2=alu result (JALR).
REQ-011 wb_sel  out  2  write-back source: 0=alu, 1=load data, 2=pc+4.
REQ-012 alu_src_b  out  1  ALU operand B: 0=rs2, 1=immediate.
REQ-013 imm_fmt  out  3  immediate format: 0=U, 1=I, 2=S, 3=B, 4=J.
REQ-014 state  out  3  current state code. illegal  out  1  sticky trap flag. instret  out  1  one-cycle retire pulse.

Function
REQ-015 States and codes SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6-7 SHALL go to FETCH.
REQ-016 FETCH: imem_req SHALL be 1 until imem_ready is sampled 1. In that cycle, ir_we SHALL be 1 and the next state is DECODE. There is no timeout.
REQ-017 DECODE: one cycle. Opcode class from instr[6:0]:
- LUI 0110111 and AUIPC 0010111 -> U
- JALR 1100111, LOAD 0000011, OP-IMM 0010011 and FENCE 0001111 -> I
- STORE 0100011 -> S
- BRANCH 1100011 -> B
- JAL 1101111 -> J
- OP 0110011 -> R
- any other opcode -> illegal.
instr[1:0]!=2'b11 SHALL also be illegal.
REQ-018 imm_fmt SHALL be decoded combinationally from instr in DECODE, EXEC, MEM and WB. R-type SHALL drive 1. alu_src_b SHALL be 0 for R and B, and 1 otherwise.
REQ-019 EXEC: one cycle.
- BRANCH: pc_we=1; pc_sel=1 if br_taken, else 0; instret=1; next state FETCH.
- LOAD and STORE: next state MEM.
- FENCE: pc_we=1 with pc_sel=0; instret=1; next state FETCH.
- All others: next state WB.
REQ-020 MEM: dmem_req SHALL be 1 until dmem_ready=1. dmem_we SHALL equal 1 for STORE only.
- STORE, on ready: pc_we=1, pc_sel=0, instret=1, next state FETCH.
- LOAD, on ready: next state WB.
REQ-021 WB: one cycle; rf_we=1 only if instr[11:7]!=0.
- wb_sel: 1 for LOAD, 2 for JAL and JALR, 0 otherwise.
- pc_we=1 with pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
- instret=1; next state FETCH.
REQ-022 TRAP: all strobes and requests SHALL be 0 and illegal SHALL be 1. The FSM SHALL leave TRAP only via reset.
REQ-023 With TRAP_ON_ILLEGAL=0, an illegal opcode SHALL take DECODE -> EXEC with pc_we=1, pc_sel=0, instret=1, then FETCH.
REQ-024 At most one of pc_we, ir_we and rf_we SHALL be 1 in any cycle, except in WB, where rf_we and pc_we are both 1.
REQ-025 Retire latency in cycles, with zero-wait memory (ready=1 in the first request cycle):
- BRANCH and FENCE: 3
- ALU, LUI, AUIPC, JAL and JALR: 4
- STORE: 4
- LOAD: 5
Each wait cycle adds 1.
REQ-026 imem_ready and dmem_ready SHALL be ignored outside their owning state.

Reset
REQ-027 With rst_n=0 at a clock edge, state SHALL become FETCH and illegal 0. All strobes and requests SHALL be 0 during the reset cycle.
REQ-028 Reset asserted mid-handshake (FETCH or MEM waiting) SHALL drop the request the next cycle. Readiness pending at that point SHALL be ignored.
REQ-029 After reset release, imem_req SHALL be 1 in the first cycle.

Structure
REQ-030 A shared package SHALL hold:
- the state enum and codes
- the opcode constants
- the imm_fmt codes U/I/S/B/J = 0..4
- the pc_sel and wb_sel codes.
REQ-031 One sub-module, ctrl_opdecode, SHALL be combinational. It SHALL map instr to opcode class, imm_fmt, alu_src_b and the illegal flag. The FSM and strobe logic SHALL remain in core_ctrl_fsm.

Verification
REQ-032 Zero-wait memory, instr=0x00500093 (addi x1,x0,5):
- states go 0->1->2->4->0
- WB: rf_we=1, wb_sel=0, pc_sel=0
- instret pulses once, on cycle 4.
REQ-033 instr=0x0000A103 (lw x2,0(x1)), dmem_ready held low 3 cycles:
- dmem_req=1 for 4 cycles with dmem_we=0
- WB: wb_sel=1
- retire on cycle 8.
REQ-034 instr=0x00208463 (beq), br_taken=1 -> EXEC: pc_we=1, pc_sel=1, rf_we=0; retire on cycle 3. Repeat with br_taken=0 -> pc_sel=0.
REQ-035 instr=0x008000EF (jal x1,8) -> WB: rf_we=1, wb_sel=2, pc_sel=1, imm_fmt=4. With instr=0x000000E7 (jalr) -> pc_sel=2, imm_fmt=1.
REQ-036 instr=0x0000007F, TRAP_ON_ILLEGAL=1 -> state=5 and illegal=1 from cycle 3. Held 100 cycles with no strobes; rst_n=0 for one cycle -> state=0, imem_req=1.
REQ-037 Reset pulse during the MEM wait of a store -> dmem_req=0 the next cycle, with no pc_we and no instret.

Source files
------------

// File: rtl/core_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle core control FSM:
// state codes, opcodes, opcode classes and mux select codes.
package core_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR,
    C_BRANCH, C_LOAD, C_STORE,
    C_OPIMM, C_OP, C_FENCE, C_ILL
  } opcls_e;

  localparam logic [2:0] IMM_U = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

endpackage

// File: rtl/ctrl_opdecode.sv
// Combinational opcode decoder: opcode -> class, imm_fmt,
// alu_src_b, illegal. Ports: opcode in; cls/imm_fmt/alu_src_b/illegal out.
import core_ctrl_fsm_pkg::*;

module ctrl_opdecode (
  input  logic [6:0] opcode,
  output opcls_e     cls,
  output logic [2:0] imm_fmt,
  output logic       alu_src_b,
  output logic       illegal
);

  always_comb begin
    cls = C_ILL;
    unique case (1'b1)
      (opcode == OPC_LUI):    cls = C_LUI;
      (opcode == OPC_AUIPC):  cls = C_AUIPC;
      (opcode == OPC_JAL):    cls = C_JAL;
      (opcode == OPC_JALR):   cls = C_JALR;
      (opcode == OPC_BRANCH): cls = C_BRANCH;
      (opcode == OPC_LOAD):   cls = C_LOAD;
      (opcode == OPC_STORE):  cls = C_STORE;
      (opcode == OPC_OPIMM):  cls = C_OPIMM;
      (opcode == OPC_OP):     cls = C_OP;
      (opcode == OPC_FENCE):  cls = C_FENCE;
      default:                cls = C_ILL;
    endcase
  end

  always_comb begin
    imm_fmt   = IMM_U;
    alu_src_b = 1'b1;
    case (cls)
      C_LUI, C_AUIPC: imm_fmt = IMM_U;
      C_JALR, C_LOAD,
      C_OPIMM, C_FENCE: imm_fmt = IMM_I;
      C_STORE: imm_fmt = IMM_S;
      C_BRANCH: begin
        imm_fmt   = IMM_B;
        alu_src_b = 1'b0;
      end
      C_JAL: imm_fmt = IMM_J;
      // R-type has no immediate; I is driven as a benign default
      C_OP: begin
        imm_fmt   = IMM_I;
        alu_src_b = 1'b0;
      end
      default: imm_fmt = IMM_U;
    endcase
  end

  assign illegal = (cls == C_ILL) || (opcode[1:0] != 2'b11);

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb/trap.
// Ports: clk, rst_n, instr, br_taken, mem handshakes, write strobes, selects, status.
import core_ctrl_fsm_pkg::*;

module core_ctrl_fsm #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  wb_sel,
  output logic        alu_src_b,
  output logic [2:0]  imm_fmt,
  output logic [2:0]  state,
  output logic        illegal,
  output logic        instret
);

  state_e     st, nx;
  opcls_e     cls;
  logic [2:0] dec_imm;
  logic       dec_ill;
  logic       unused_hi;

  assign unused_hi = ^instr[31:12];

  ctrl_opdecode u_dec (
    .opcode    (instr[6:0]),
    .cls       (cls),
    .imm_fmt   (dec_imm),
    .alu_src_b (alu_src_b),
    .illegal   (dec_ill)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) st <= S_FETCH;
    else        st <= nx;
  end

  always_comb begin
    nx = S_FETCH;
    case (st)
      S_FETCH:  nx = imem_ready ? S_DECODE : S_FETCH;
      S_DECODE: nx = (dec_ill && TRAP_ON_ILLEGAL)
                     ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (dec_ill || cls == C_BRANCH
            || cls == C_FENCE)
          nx = S_FETCH;
        else if (cls == C_LOAD || cls == C_STORE)
          nx = S_MEM;
        else
          nx = S_WB;
      end
      S_MEM: begin
        if (!dmem_ready)         nx = S_MEM;
        else if (cls == C_STORE) nx = S_FETCH;
        else                     nx = S_WB;
      end
      S_WB:    nx = S_FETCH;
      S_TRAP:  nx = S_TRAP;
      default: nx = S_FETCH;
    endcase
  end

  // Strobes are forced low while rst_n is low so a reset
  // landing mid-handshake drops requests immediately.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    pc_sel   = PC_PLUS4;
    wb_sel   = WB_ALU;
    instret  = 1'b0;
    if (rst_n) begin
      case (st)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          if (cls == C_BRANCH) begin
            pc_we   = 1'b1;
            pc_sel  = br_taken ? PC_IMM : PC_PLUS4;
            instret = 1'b1;
          end else if (cls == C_FENCE || dec_ill) begin
            pc_we   = 1'b1;
            instret = 1'b1;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls == C_STORE);
          if (dmem_ready && cls == C_STORE) begin
            pc_we   = 1'b1;
            instret = 1'b1;
          end
        end
        S_WB: begin
          rf_we   = |instr[11:7];
          pc_we   = 1'b1;
          instret = 1'b1;
          unique case (1'b1)
            (cls == C_LOAD): wb_sel = WB_LOAD;
            (cls == C_JAL),
            (cls == C_JALR): wb_sel = WB_PC4;
            default:         wb_sel = WB_ALU;
          endcase
          unique case (1'b1)
            (cls == C_JAL):  pc_sel = PC_IMM;
            (cls == C_JALR): pc_sel = PC_ALU;
            default:         pc_sel = PC_PLUS4;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign imm_fmt = (st == S_DECODE || st == S_EXEC
                    || st == S_MEM || st == S_WB)
                   ? dec_imm : IMM_U;
  assign state   = st;
  assign illegal = (st == S_TRAP);

endmodule
